univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the team's 4-bit left/right serial shifter. It supports hold, left shift, right shift and parallel load, with registered serial output and a per-frame shift counter. It sits between parallel datapaths and serial links, serialising and deserialising `WIDTH`-bit words. A compile-time option adds circular rotate.

---
 rtl/univ_shift_pkg.sv | 17 +
 rtl/shift_frame_cnt.sv | 46 ++++
 rtl/univ_shift_reg.sv | 87 ++++++++
 tb/tb_univ_shift_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types and helpers for the universal shift register.
// Mode encoding matches the 2-bit mode port of univ_shift_reg.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Default shift-counter width; never below 1 bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Modulo-WIDTH shift counter with a one-cycle frame_done pulse on wrap.
// clr has priority over inc, so a load on the wrap edge suppresses the pulse.
module shift_frame_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load, framed shift count.
// Define SHREG_ROTATE_EN to let rot turn a shift into a circular rotate.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             rot,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             do_shl, do_shr, do_load;
  logic             fill_l, fill_r;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    do_shl  = en && (mode_s == MODE_SHL);
    do_shr  = en && (mode_s == MODE_SHR);
    do_load = en && (mode_s == MODE_LOAD);
  end

`ifdef SHREG_ROTATE_EN
  // Rotate recirculates the outgoing bit in place of the serial input.
  assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
  assign fill_r = rot ? q_q[0]       : sin_r;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_l     = sin_l;
  assign fill_r     = sin_r;
`endif

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (do_load) begin
      q_d = pdin;
    end else if (do_shl) begin
      q_d    = {q_q[WIDTH-2:0], fill_l};
      sout_d = q_q[WIDTH-1];
    end else if (do_shr) begin
      q_d    = {fill_r, q_q[WIDTH-1:1]};
      sout_d = q_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  shift_frame_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc        (do_shl | do_shr),
    .clr        (do_load),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign q    = q_q;
  assign sout = sout_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) using a reference model and scoreboard.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic         sin_l, sin_r, rot;
  logic [W-1:0] pdin;
  logic [W-1:0] q;
  logic         sout;
  logic [2:0]   cnt;
  logic         frame_done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sin_l      (sin_l),
    .sin_r      (sin_r),
    .rot        (rot),
    .pdin       (pdin),
    .q          (q),
    .sout       (sout),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         sout;
    logic [2:0]   cnt;
    logic         fd;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] m_q;
  logic         m_sout;
  int           m_cnt;
  logic         m_fd;

`ifdef SHREG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_sout = 1'b0; m_cnt = 0; m_fd = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [1:0] md, input logic sl,
                            input logic sr, input logic rt, input logic [W-1:0] pd);
    logic fill;
    m_fd = 1'b0;
    if (e && md == 2'b11) begin
      m_q   = pd;
      m_cnt = 0;
    end else if (e && (md == 2'b01 || md == 2'b10)) begin
      if (md == 2'b01) begin
        fill   = (ROT_EN && rt) ? m_q[W-1] : sl;
        m_sout = m_q[W-1];
        m_q    = {m_q[W-2:0], fill};
      end else begin
        fill   = (ROT_EN && rt) ? m_q[0] : sr;
        m_sout = m_q[0];
        m_q    = {fill, m_q[W-1:1]};
      end
      if (m_cnt == W - 1) begin
        m_cnt = 0;
        m_fd  = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one cycle, push model expectation, then pop and compare after the edge.
  task automatic step(input logic e, input logic [1:0] md, input logic sl,
                      input logic sr, input logic rt, input logic [W-1:0] pd);
    exp_t x;
    @(negedge clk);
    en = e; mode = md; sin_l = sl; sin_r = sr; rot = rt; pdin = pd;
    model_step(e, md, sl, sr, rt, pd);
    x.q = m_q; x.sout = m_sout; x.cnt = m_cnt[2:0]; x.fd = m_fd;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("q", 32'(q), 32'(x.q));
      chk("sout", 32'(sout), 32'(x.sout));
      chk("cnt", 32'(cnt), 32'(x.cnt));
      chk("frame_done", 32'(frame_done), 32'(x.fd));
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, v);
  endtask

  logic [W-1:0] shl_q_tab [8];
  logic         shl_s_tab [8];

  initial begin
    shl_q_tab = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    shl_s_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b0; en = 1'b0; mode = 2'b00; sin_l = 1'b0; sin_r = 1'b0; rot = 1'b0; pdin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_sout", 32'(sout), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // asynchronous reset mid-cycle after a load and a shift
    load(8'hFF);
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_sout", 32'(sout), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // left serialise
    load(8'hA5);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
      chk("ser_q", 32'(q), 32'(shl_q_tab[i]));
      chk("ser_sout", 32'(sout), 32'(shl_s_tab[i]));
      chk("ser_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
    end
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    chk("ser_fd_after", 32'(frame_done), 32'd0);

    // right shift fill
    load(8'h81);
    step(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, '0);
    chk("shr_q1", 32'(q), 32'hC0);
    chk("shr_s1", 32'(sout), 32'd1);
    chk("shr_c1", 32'(cnt), 32'd1);
    step(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, '0);
    chk("shr_q2", 32'(q), 32'hE0);
    chk("shr_s2", 32'(sout), 32'd0);
    chk("shr_c2", 32'(cnt), 32'd2);

    // hold with en low, then abort via load
    load(8'h5A);
    repeat (3) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) begin
      step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'hFF);
      chk("hold_q", 32'(q), 32'hD7);
      chk("hold_cnt", 32'(cnt), 32'd3);
    end
    load(8'h3C);
    chk("abort_q", 32'(q), 32'h3C);
    chk("abort_cnt", 32'(cnt), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);

    // rotate left
    load(8'h81);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, '0);
    chk("rot_q1", 32'(q), ROT_EN ? 32'h03 : 32'h02);
    chk("rot_s1", 32'(sout), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, '0);
      chk("rot_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("rot_q8", 32'(q), ROT_EN ? 32'h81 : 32'h00);

    // load on the wrap edge
    load(8'h0F);
    repeat (7) step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, '0);
    chk("wrap_pre_cnt", 32'(cnt), 32'd7);
    load(8'hE7);
    chk("wrap_cnt", 32'(cnt), 32'd0);
    chk("wrap_fd", 32'(frame_done), 32'd0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    chk("wrap_fd2", 32'(frame_done), 32'd0);

    // mixed-direction frame keeps counting
    load(8'h00);
    for (int i = 0; i < 8; i++)
      step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b0, '0);
    chk("mix_fd", 32'(frame_done), 32'd1);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
